// File: rtl/exmem_pkg.sv
// Shared definitions for the EX/MEM skid-buffer pipeline register:
// default widths, the RegWrite bit position and the occupancy state enum.
package exmem_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_RD_W     = 5;
    localparam int DEF_WB_W     = 2;
    localparam int DEF_M_W      = 3;

    // Position of RegWrite inside the write-back control field
    localparam int REGWRITE_BIT = 1;

    // Occupancy of the two-entry buffer
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/exmem_slot.sv
// One entry of the EX/MEM skid buffer. The clear input kills the control
// fields (WB, M, RD) so a dead slot presents a bubble; the ALU result and
// store data keep their last value. Clear has priority over load.
module exmem_slot
    import exmem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_W   = DEF_RD_W,
    parameter int WB_W   = DEF_WB_W,
    parameter int M_W    = DEF_M_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [WB_W-1:0]   new_wb,
    input  logic [M_W-1:0]    new_m,
    input  logic [RD_W-1:0]   new_rd,
    input  logic [DATA_W-1:0] new_alu,
    input  logic [DATA_W-1:0] new_data,
    output logic [WB_W-1:0]   wb,
    output logic [M_W-1:0]    m,
    output logic [RD_W-1:0]   rd,
    output logic [DATA_W-1:0] alu,
    output logic [DATA_W-1:0] data
);

    // Entry storage: async reset to zero, clear kills control, load captures all fields
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb   <= '0;
            m    <= '0;
            rd   <= '0;
            alu  <= '0;
            data <= '0;
        end else if (clear) begin
            wb   <= '0;
            m    <= '0;
            rd   <= '0;
        end else if (load) begin
            wb   <= new_wb;
            m    <= new_m;
            rd   <= new_rd;
            alu  <= new_alu;
            data <= new_data;
        end
    end

endmodule

// File: rtl/exmem_skid.sv
// EX/MEM pipeline register built as a two-entry skid buffer. The main slot
// drives the outputs; the skid slot catches the entry accepted while the
// downstream stalls, so in_ready can come straight from a flop.
// Optional feature: define EXMEM_SKID_FWD_EN to add the forwarding outputs
// fwdValid / fwdRD / fwdALU taken combinationally from the main slot.
module exmem_skid
    import exmem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_W   = DEF_RD_W,
    parameter int WB_W   = DEF_WB_W,
    parameter int M_W    = DEF_M_W
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WB_W-1:0]   WB,
    input  logic [M_W-1:0]    M,
    input  logic [RD_W-1:0]   RD,
    input  logic [DATA_W-1:0] saidaALU,
    input  logic [DATA_W-1:0] entradaData,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef EXMEM_SKID_FWD_EN
    output logic              fwdValid,
    output logic [RD_W-1:0]   fwdRD,
    output logic [DATA_W-1:0] fwdALU,
`endif
    output logic [WB_W-1:0]   registradorWB,
    output logic [M_W-1:0]    registradorM,
    output logic [RD_W-1:0]   registradorRD,
    output logic [DATA_W-1:0] registradorALU,
    output logic [DATA_W-1:0] saidaData
);

    skid_state_t state;
    skid_state_t state_next;

    logic in_fire;
    logic out_fire;

    logic main_load;
    logic main_from_skid;
    logic main_clear;
    logic skid_load;
    logic skid_clear;

    logic [WB_W-1:0]   skid_wb;
    logic [M_W-1:0]    skid_m;
    logic [RD_W-1:0]   skid_rd;
    logic [DATA_W-1:0] skid_alu;
    logic [DATA_W-1:0] skid_data;

    logic [WB_W-1:0]   main_new_wb;
    logic [M_W-1:0]    main_new_m;
    logic [RD_W-1:0]   main_new_rd;
    logic [DATA_W-1:0] main_new_alu;
    logic [DATA_W-1:0] main_new_data;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Next occupancy and slot steering; flush overrides every other event
    always_comb begin
        state_next     = state;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        main_clear     = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        if (flush) begin
            state_next = ST_EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_load  = 1'b1;
                        state_next = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_load  = 1'b1;
                    end else if (in_fire) begin
                        skid_load  = 1'b1;
                        state_next = ST_FULL;
                    end else if (out_fire) begin
                        main_clear = 1'b1;
                        state_next = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        state_next     = ST_ONE;
                    end
                end
                default: begin
                    state_next = ST_EMPTY;
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    // Main slot refills either from the input bus or from the skid slot
    always_comb begin
        main_new_wb   = WB;
        main_new_m    = M;
        main_new_rd   = RD;
        main_new_alu  = saidaALU;
        main_new_data = entradaData;
        if (main_from_skid) begin
            main_new_wb   = skid_wb;
            main_new_m    = skid_m;
            main_new_rd   = skid_rd;
            main_new_alu  = skid_alu;
            main_new_data = skid_data;
        end
    end

    // Occupancy state with registered handshake outputs
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state     <= state_next;
            out_valid <= (state_next != ST_EMPTY);
            in_ready  <= (state_next != ST_FULL);
        end
    end

    exmem_slot #(
        .DATA_W (DATA_W),
        .RD_W   (RD_W),
        .WB_W   (WB_W),
        .M_W    (M_W)
    ) u_main (
        .clk      (Clock),
        .rst      (Reset),
        .load     (main_load),
        .clear    (main_clear),
        .new_wb   (main_new_wb),
        .new_m    (main_new_m),
        .new_rd   (main_new_rd),
        .new_alu  (main_new_alu),
        .new_data (main_new_data),
        .wb       (registradorWB),
        .m        (registradorM),
        .rd       (registradorRD),
        .alu      (registradorALU),
        .data     (saidaData)
    );

    exmem_slot #(
        .DATA_W (DATA_W),
        .RD_W   (RD_W),
        .WB_W   (WB_W),
        .M_W    (M_W)
    ) u_skid (
        .clk      (Clock),
        .rst      (Reset),
        .load     (skid_load),
        .clear    (skid_clear),
        .new_wb   (WB),
        .new_m    (M),
        .new_rd   (RD),
        .new_alu  (saidaALU),
        .new_data (entradaData),
        .wb       (skid_wb),
        .m        (skid_m),
        .rd       (skid_rd),
        .alu      (skid_alu),
        .data     (skid_data)
    );

`ifdef EXMEM_SKID_FWD_EN
    // Forwarding view of the entry currently in MEM; only real register writes qualify
    assign fwdValid = out_valid & registradorWB[REGWRITE_BIT] & (registradorRD != '0);
    assign fwdRD    = registradorRD;
    assign fwdALU   = registradorALU;
`endif

endmodule
